// File: rtl/z_run_monitor.sv
// ---------------------------------------------------------------------------
// z_run_monitor
//
// Watches the registered `z` output of the serial sequence detector over a
// window opened by `start` and closed by `stop` (the stop edge is still
// sampled). Three figures are accumulated:
//   hit_count : cycles with z=1            (saturates at 2^CNT_W-1)
//   run_count : number of 0->1 runs        (saturates at 2^CNT_W-1)
//   max_run   : longest consecutive z=1    (saturates at 2^RUN_W-1)
// The result is then held with result_valid=1 until result_ack.
//
// Ports
//   i_clk          clock, rising edge
//   i_resetn       synchronous active-low reset
//   i_z            detector output (already registered upstream)
//   i_start        one-cycle request to open a window (IDLE only)
//   i_stop         one-cycle request to close the window (MEASURE only)
//   i_result_ack   consumer accepts the result (REPORT only)
//   o_busy         high while measuring
//   o_result_valid high while the result is presented
//   o_hit_count    cycles with z=1 inside the window
//   o_run_count    number of runs inside the window
//   o_max_run      longest run inside the window
// ---------------------------------------------------------------------------
module z_run_monitor #(
    parameter int CNT_W = 8,
    parameter int RUN_W = 6
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_z,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_result_ack,
    output logic             o_busy,
    output logic             o_result_valid,
    output logic [CNT_W-1:0] o_hit_count,
    output logic [CNT_W-1:0] o_run_count,
    output logic [RUN_W-1:0] o_max_run
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_clear;
    logic             w_sample;

    logic             r_busy;
    logic             r_result_valid;
    logic [CNT_W-1:0] r_hit_count;
    logic [CNT_W-1:0] r_run_count;
    logic [RUN_W-1:0] r_max_run;
    logic [RUN_W-1:0] r_cur_run;
    logic             r_z_prev;

    // Saturating increments of the live counters.
    logic [CNT_W-1:0] w_hit_inc;
    logic [CNT_W-1:0] w_run_inc;
    logic [RUN_W-1:0] w_cur_inc;

    assign w_hit_inc = (r_hit_count == CNT_MAX) ? r_hit_count : r_hit_count + CNT_W'(1);
    assign w_run_inc = (r_run_count == CNT_MAX) ? r_run_count : r_run_count + CNT_W'(1);
    assign w_cur_inc = (r_cur_run   == RUN_MAX) ? r_cur_run   : r_cur_run   + RUN_W'(1);

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and datapath controls
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_sample     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_MEASURE;
                    w_clear      = 1'b1;
                end
            end
            ST_MEASURE: begin
                // The stop edge is part of the window, so it is sampled too.
                w_sample = 1'b1;
                if (i_stop) begin
                    w_state_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                // start is deliberately not looked at here, even alongside ack.
                if (i_result_ack) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with
    // the state register without a decode stage on the outputs.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_busy         <= (w_state_next == ST_MEASURE);
            r_result_valid <= (w_state_next == ST_REPORT);
        end
    end

    // Measurement datapath
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_hit_count <= '0;
            r_run_count <= '0;
            r_max_run   <= '0;
            r_cur_run   <= '0;
            r_z_prev    <= 1'b0;
        end else if (w_clear) begin
            // z_prev cleared so a run already high at the first sample counts.
            r_hit_count <= '0;
            r_run_count <= '0;
            r_max_run   <= '0;
            r_cur_run   <= '0;
            r_z_prev    <= 1'b0;
        end else if (w_sample) begin
            r_z_prev <= i_z;
            if (i_z) begin
                r_hit_count <= w_hit_inc;
                r_cur_run   <= w_cur_inc;
                if (!r_z_prev) begin
                    r_run_count <= w_run_inc;
                end
                if (w_cur_inc > r_max_run) begin
                    r_max_run <= w_cur_inc;
                end
            end else begin
                r_cur_run <= '0;
            end
        end
    end

    assign o_busy         = r_busy;
    assign o_result_valid = r_result_valid;
    assign o_hit_count    = r_hit_count;
    assign o_run_count    = r_run_count;
    assign o_max_run      = r_max_run;

endmodule

// File: doc/z_run_monitor.md
Name: z_run_monitor

Overview:
- Downstream consumer of the serial sequence detector's `z` output.
- Measures detector activity over a software-delimited window.
- Accumulates three figures:
  - total cycles with `z`=1;
  - number of distinct `z` runs;
  - longest run.
- Presents the result through a valid/ack handshake for a status register or display stage.

Parameters:
- CNT_W, 8, width of `hit_count` and `run_count`; both saturate at 2^CNT_W-1.
- RUN_W, 6, width of `max_run` and the internal current-run counter; both saturate at 2^RUN_W-1.

Ports:
- Clock  in  1  single clock; all logic on rising edge.
- Resetn  in  1  synchronous, active-low reset.
- z  in  1  detector output; already registered upstream.
- start  in  1  one-cycle request to open a measurement window.
- stop  in  1  one-cycle request to close the window.
- result_ack  in  1  consumer accepts the result.
- busy  out  1  high while state is MEASURE.
- result_valid  out  1  high while state is REPORT.
- hit_count  out  CNT_W  cycles with `z`=1 inside the window.
- run_count  out  CNT_W  number of 0->1 runs inside the window.
- max_run  out  RUN_W  longest consecutive `z`=1 run inside the window.

Behaviour:
- Reset:
  - Resetn=0 at a rising edge forces state IDLE.
  - busy=0, result_valid=0, hit_count=0, run_count=0, max_run=0.
  - Internal cur_run=0, z_prev=0.
  - Reset mid-MEASURE or mid-REPORT aborts; no partial result is kept.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, MEASURE, REPORT.
- IDLE:
  - busy=0, result_valid=0.
  - Result registers hold the last reported values.
  - start=1 at edge: go to MEASURE; clear hit_count, run_count, max_run, cur_run, z_prev. `z` is not sampled at this edge.
  - stop and result_ack are ignored.
- MEASURE:
  - Every edge samples `z`, including the edge at which stop=1 (window is inclusive).
  - If z=1:
    - hit_count += 1, saturating.
    - cur_run += 1, saturating.
    - If z_prev=0, run_count += 1, saturating.
    - max_run <= max(max_run, cur_run+1), saturating.
  - If z=0: cur_run <= 0.
  - z_prev <= z.
  - A run already high on the first sampled edge counts as a run (z_prev is cleared on start).
  - stop=1: go to REPORT.
  - start is ignored. start and stop together: stop wins.
- REPORT:
  - result_valid=1; counters frozen; `z` ignored.
  - result_ack=1 at edge: go to IDLE; result_valid is 0 from the next cycle.
  - start is ignored, including in the same cycle as result_ack. A new window needs start while in IDLE.
  - Outputs are stable for the entire time result_valid=1.
- Latency:
  - stop seen at edge t gives result_valid=1 after edge t, with final counts.
  - result_ack at edge t gives result_valid=0 after edge t.

Test Plan:
- Reset: hold Resetn=0 for 2 edges, with start=1 and z=1 toggling -> busy=0, result_valid=0, all counts 0.
- Basic window:
  - Stimulus: start at edge 0; z=0,1,0,1,1,1,0,1,1 on edges 1-9; stop=1 at edge 9.
  - Response: busy=1 after edges 0-8; result_valid=1 after edge 9; hit_count=6, run_count=3, max_run=3.
- Saturation (defaults):
  - Stimulus: start, then z=1 for 300 edges, then stop.
  - Response: hit_count=255, run_count=1, max_run=63, no wrap to 0.
  - Alternating z=1,0 for 600 edges -> run_count=255, max_run=1.
- Handshake hold:
  - Stimulus: after a result, keep result_ack=0 for 5 cycles and pulse start in cycle 3.
  - Response: result_valid stays 1 and values are unchanged.
  - Then result_ack=1 -> result_valid=0 and busy=0 next cycle; the start pulse had no effect.
- Abort:
  - Stimulus: Resetn=0 for one edge in the middle of MEASURE (hit_count=4 so far), then stop=1.
  - Response: IDLE with all counts 0; stop ignored; result_valid never asserts.
- Simultaneous events:
  - start and stop together in IDLE -> MEASURE entered.
  - start and stop together in MEASURE -> REPORT, with `z` at that edge counted.
  - result_ack together with start in REPORT -> IDLE, not MEASURE.
